sram_boot_loader: RTL and testbench
===================================

// Module: sram_boot_loader
// PURPOSE
//  Sits between the SLC-3 memory subsystem (CPU-side SRAM controls/data) and the SRAM pins/tristate.
//  After reset (or a Reload request) it copies N_WORDS from a program ROM into SRAM addresses
//  0..N_WORDS-1 while holding the CPU in reset. It then hands the SRAM bus to the CPU
//  combinationally. SRAM controls are active-low.
// PARAMETERS
//  N_WORDS    256  words copied from ROM (0..65536); 0 = no copy
//  WE_CYCLES  2    cycles sram_WE is held low per word (>=1)
// PORTS
//  Clk            in   1   system clock; all state changes on rising edge
//  Reset          in   1   synchronous, active-low reset
//  Reload         in   1   active-high request to restart the copy
//  rom_addr       out  16  ROM read address; rom_data is valid 1 cycle later
//  rom_data       in   16  ROM read data
//  cpu_CE/UB/LB/OE/WE  in 1 each  CPU-side SRAM controls (active-low)
//  cpu_ADDR       in   20  CPU-side SRAM address
//  cpu_data_write in   16  CPU write data
//  sram_CE/UB/LB/OE/WE out 1 each SRAM pin controls (active-low)
//  sram_ADDR      out  20  SRAM address pins
//  sram_data_write out 16  data driven to the tristate
//  sram_drive     out  1   tristate output enable (1 = drive Data bus)
//  cpu_hold       out  1   1 = keep CPU in reset (copy in progress)
//  init_done      out  1   1 = copy complete; bus passed through
//  load_count     out  17  words written since the copy started
// BEHAVIOUR
//  Reset (Reset==0 at an edge): CE=UB=LB=OE=WE=1, sram_drive=0, sram_ADDR=0, sram_data_write=0,
//   rom_addr=0, load_count=0, cpu_hold=1, init_done=0. State goes to FETCH (or DONE if N_WORDS==0).
//   The same applies mid-copy: the write is aborted and WE is high after that edge.
//  States FETCH -> SETUP -> WRITE -> HOLD -> (FETCH | DONE). All loader outputs are registered.
//   FETCH: rom_addr=idx; controls idle (all 1); sram_drive=0; 1 cycle.
//   SETUP: latch rom_data; sram_ADDR={4'b0,idx}; sram_data_write=rom_data; CE=UB=LB=0;
//          WE=1; OE=1; sram_drive=1; 1 cycle.
//   WRITE: WE=0 for exactly WE_CYCLES cycles; ADDR and data are stable.
//   HOLD:  WE=1 and ADDR/data/drive unchanged for 1 cycle; load_count++.
//          If idx==N_WORDS-1, go to DONE; otherwise idx++ and go to FETCH.
//  Per word: 3+WE_CYCLES cycles. DONE is entered N_WORDS*(3+WE_CYCLES) cycles after reset release.
//  idx is 16 bits and never exceeds N_WORDS-1 (no wrap). OE is never 0 during the copy.
//  DONE: cpu_hold=0, init_done=1. sram_X = cpu_X combinationally (0-cycle latency) for
//   CE/UB/LB/OE/WE/ADDR/data_write, and sram_drive = ~cpu_WE.
//  Reload in DONE: on the next edge go to FETCH, set idx=0, load_count=0, cpu_hold=1, init_done=0.
//   Controls return to idle from that edge on.
//  Reload is ignored in FETCH/SETUP/WRITE/HOLD. Reset has priority over Reload.
//  cpu_* inputs are ignored outside DONE. The CPU can never assert sram_WE during a copy.
// TESTING
//  1 N_WORDS=4, WE_CYCLES=2, rom_data=addr^16'hA5A5; release Reset -> 4 writes to addr 0..3 with
//    data A5A5/A5A4/A5A7/A5A6, each WE-low exactly 2 cycles; init_done=1 at cycle 20; load_count=4.
//  2 In DONE, cpu_OE=0, cpu_WE=1, cpu_ADDR=20'h00012 -> same cycle sram_OE=0, sram_ADDR=20'h00012,
//    sram_drive=0; then cpu_WE=0 -> sram_WE=0, sram_drive=1.
//  3 Reset=0 during the WRITE of word 2 -> WE=1 and drive=0 after that edge; on release the copy
//    restarts at addr 0 with load_count=0.
//  4 Reload=1 in DONE -> cpu_hold=1 next cycle and 4 words rewritten; Reload pulses during the copy
//    -> still exactly 4 writes, with no restart.
//  5 N_WORDS=0 -> init_done=1 from the first cycle after reset release; sram_WE is never low
//    from the loader.
//  6 Assertion (all runs): while the loader drives WE=0, ADDR and data are stable and OE=1;
//    cpu_WE toggling during the copy never reaches sram_WE.

Source files
------------

// File: rtl/sram_boot_loader_if.sv
// SRAM-style control/address/data bundle, used for both the CPU side and the pin side.
interface sram_boot_loader_if;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;
  logic [15:0] data_write;

  modport master (output CE, UB, LB, OE, WE, ADDR, data_write);
  modport slave  (input  CE, UB, LB, OE, WE, ADDR, data_write);
endinterface

// File: rtl/sram_boot_loader.sv
// Copies N_WORDS from a program ROM into SRAM after reset or Reload while holding the CPU,
// then passes the CPU's SRAM bus straight through to the pins.
//
// state | meaning
// FETCH | rom_addr presented for the current word, bus idle
// SETUP | address and chip selects driven, ROM data latched at the end
// WRITE | WE low for WE_CYCLES cycles, address/data stable
// HOLD  | WE released, word counted, advance or finish
// DONE  | CPU owns the SRAM bus; Reload restarts the copy
module sram_boot_loader #(
  parameter int N_WORDS   = 256,
  parameter int WE_CYCLES = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Reload,
  output logic [15:0]              rom_addr,
  input  logic [15:0]              rom_data,
  sram_boot_loader_if.slave        cpu,
  sram_boot_loader_if.master       sram,
  output logic                     sram_drive,
  output logic                     cpu_hold,
  output logic                     init_done,
  output logic [16:0]              load_count
);

  typedef enum logic [2:0] {FETCH, SETUP, WRITE, HOLD, DONE} state_t;

  localparam int             CNT_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [15:0]    LAST_IDX = (N_WORDS > 0) ? 16'(N_WORDS - 1) : 16'd0;
  localparam state_t         START    = (N_WORDS == 0) ? DONE : FETCH;

  // control vectors ordered {CE, UB, LB, OE, WE}
  localparam logic [4:0] CTL_IDLE = 5'b11111;
  localparam logic [4:0] CTL_SEL  = 5'b00011;
  localparam logic [4:0] CTL_WR   = 5'b00010;

  state_t             state, state_nxt;
  logic [15:0]        idx, idx_nxt;
  logic [CNT_W-1:0]   we_cnt, we_cnt_nxt;
  logic [15:0]        rom_addr_nxt;
  logic [4:0]         ctl_q, ctl_nxt;
  logic [19:0]        addr_q, addr_nxt;
  logic [15:0]        data_q, data_nxt;
  logic               drive_q, drive_nxt;
  logic               hold_nxt, done_nxt;
  logic [16:0]        count_nxt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= START;
      idx        <= 16'd0;
      we_cnt     <= '0;
      rom_addr   <= 16'd0;
      ctl_q      <= CTL_IDLE;
      addr_q     <= 20'd0;
      data_q     <= 16'd0;
      drive_q    <= 1'b0;
      cpu_hold   <= 1'b1;
      init_done  <= 1'b0;
      load_count <= 17'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      we_cnt     <= we_cnt_nxt;
      rom_addr   <= rom_addr_nxt;
      ctl_q      <= ctl_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      drive_q    <= drive_nxt;
      cpu_hold   <= hold_nxt;
      init_done  <= done_nxt;
      load_count <= count_nxt;
    end
  end

  // Registered outputs are computed for the state being entered.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    we_cnt_nxt   = we_cnt;
    rom_addr_nxt = rom_addr;
    ctl_nxt      = ctl_q;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    drive_nxt    = drive_q;
    hold_nxt     = cpu_hold;
    done_nxt     = init_done;
    count_nxt    = load_count;
    case (state)
      FETCH: begin
        state_nxt = SETUP;
        ctl_nxt   = CTL_SEL;
        addr_nxt  = {4'b0000, idx};
        drive_nxt = 1'b1;
      end
      SETUP: begin
        state_nxt  = WRITE;
        data_nxt   = rom_data;
        ctl_nxt    = CTL_WR;
        we_cnt_nxt = WE_LOAD;
      end
      WRITE: begin
        if (we_cnt == '0) begin
          state_nxt = HOLD;
          ctl_nxt   = CTL_SEL;
        end else begin
          we_cnt_nxt = we_cnt - 1'b1;
        end
      end
      HOLD: begin
        count_nxt = load_count + 17'd1;
        ctl_nxt   = CTL_IDLE;
        drive_nxt = 1'b0;
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
          hold_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt    = FETCH;
          idx_nxt      = idx + 16'd1;
          rom_addr_nxt = idx + 16'd1;
        end
      end
      DONE: begin
        if (Reload) begin
          state_nxt    = FETCH;
          idx_nxt      = 16'd0;
          rom_addr_nxt = 16'd0;
          count_nxt    = 17'd0;
          ctl_nxt      = CTL_IDLE;
          drive_nxt    = 1'b0;
          hold_nxt     = 1'b1;
          done_nxt     = 1'b0;
        end else begin
          hold_nxt = 1'b0;
          done_nxt = 1'b1;
        end
      end
      default: state_nxt = START;
    endcase
  end

  // Pass-through is keyed on init_done so the CPU can never reach the pins mid-copy.
  assign {sram.CE, sram.UB, sram.LB, sram.OE, sram.WE} =
           init_done ? {cpu.CE, cpu.UB, cpu.LB, cpu.OE, cpu.WE} : ctl_q;
  assign sram.ADDR       = init_done ? cpu.ADDR       : addr_q;
  assign sram.data_write = init_done ? cpu.data_write : data_q;
  assign sram_drive      = init_done ? ~cpu.WE        : drive_q;

endmodule

// File: tb/tb_sram_boot_loader.sv
// Self-checking bench for sram_boot_loader: copy sequence, pass-through, mid-copy reset, reload, N_WORDS=0.
module tb_sram_boot_loader;
  localparam int N        = 4;
  localparam int WC       = 2;
  localparam int DONE_CYC = N * (3 + WC);

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Reload;
  logic [15:0] rom_addr, rom_data, rom_addr0;
  logic        sram_drive, cpu_hold, init_done;
  logic        sram_drive0, cpu_hold0, init_done0;
  logic [16:0] load_count, load_count0;
  logic [4:0]  sram_ctl, sram0_ctl;

  sram_boot_loader_if cpu_if ();
  sram_boot_loader_if sram_if ();
  sram_boot_loader_if sram0_if ();

  sram_boot_loader #(.N_WORDS(N), .WE_CYCLES(WC)) dut (
    .Clk(Clk), .Reset(Reset), .Reload(Reload),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu(cpu_if), .sram(sram_if),
    .sram_drive(sram_drive), .cpu_hold(cpu_hold), .init_done(init_done), .load_count(load_count)
  );

  sram_boot_loader #(.N_WORDS(0), .WE_CYCLES(WC)) dut0 (
    .Clk(Clk), .Reset(Reset), .Reload(1'b0),
    .rom_addr(rom_addr0), .rom_data(16'h0000),
    .cpu(cpu_if), .sram(sram0_if),
    .sram_drive(sram_drive0), .cpu_hold(cpu_hold0), .init_done(init_done0), .load_count(load_count0)
  );

  assign sram_ctl  = {sram_if.CE, sram_if.UB, sram_if.LB, sram_if.OE, sram_if.WE};
  assign sram0_ctl = {sram0_if.CE, sram0_if.UB, sram0_if.LB, sram0_if.OE, sram0_if.WE};

  always #5 Clk = ~Clk;

  // synchronous ROM: data for the address seen at an edge is valid after that edge
  always @(posedge Clk) rom_data <= rom_addr ^ 16'hA5A5;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // write monitor: one record per loader WE-low pulse
  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
    int          len;
  } wr_t;
  wr_t         wlog[$];
  int          we_run = 0;
  logic [19:0] run_addr;
  logic [15:0] run_data;

  always @(negedge Clk) begin
    if (cpu_hold && !sram_if.WE) begin
      if (we_run == 0) begin
        run_addr = sram_if.ADDR;
        run_data = sram_if.data_write;
      end else if (sram_if.ADDR !== run_addr || sram_if.data_write !== run_data) begin
        errors++;
        $display("FAIL we_low_stable: addr=%0h data=%0h required addr=%0h data=%0h",
                 sram_if.ADDR, sram_if.data_write, run_addr, run_data);
      end
      if (sram_if.OE !== 1'b1 || sram_drive !== 1'b1) begin
        errors++;
        $display("FAIL we_low_oe_drive: oe=%0b drive=%0b required oe=1 drive=1", sram_if.OE, sram_drive);
      end
      we_run++;
    end else if (we_run != 0) begin
      wlog.push_back('{addr: run_addr, data: run_data, len: we_run});
      we_run = 0;
    end
    if (cpu_hold0 && !sram0_if.WE) begin
      errors++;
      $display("FAIL n0_loader_we: sram_WE=0 while loader owns bus, required 1");
    end
  end

  task automatic check_writes(input string tag);
    wr_t exp_q[$];
    for (int i = 0; i < N; i++)
      exp_q.push_back('{addr: 20'(i), data: 16'(i) ^ 16'hA5A5, len: WC});
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk({tag, "_waddr"}, 64'(wlog[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_wdata"}, 64'(wlog[i].data), 64'(exp_q[i].data));
      chk({tag, "_wlen"},  64'(wlog[i].len),  64'(exp_q[i].len));
    end
  endtask

  task automatic cpu_idle();
    {cpu_if.CE, cpu_if.UB, cpu_if.LB, cpu_if.OE, cpu_if.WE} = 5'b11111;
    cpu_if.ADDR       = 20'h0;
    cpu_if.data_write = 16'h0;
  endtask

  // Counts edges until init_done; optional random CPU traffic and Reload pulses during the copy.
  task automatic wait_done(input bit noise, input bit rl, input int start, output int cycles);
    cycles = start;
    while (!init_done && cycles < 500) begin
      @(posedge Clk);
      #1;
      cycles++;
      if (!init_done) begin
        if (noise) begin
          {cpu_if.CE, cpu_if.UB, cpu_if.LB, cpu_if.OE, cpu_if.WE} = 5'($urandom);
          cpu_if.ADDR       = 20'($urandom);
          cpu_if.data_write = 16'($urandom);
        end
        if (rl) Reload = 1'($urandom);
      end
    end
    Reload = 1'b0;
    cpu_idle();
    if (!init_done) begin
      errors++;
      $display("FAIL wait_done_timeout: init_done=%0b after %0d cycles, required 1", init_done, cycles);
    end
  endtask

  typedef struct {
    logic [4:0]  ctl;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [4:0]  e_ctl;
    logic [19:0] e_addr;
    logic [15:0] e_wd;
    logic        e_drive;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int cyc;
    bit found;
    logic [4:0]  r_ctl;
    logic [19:0] r_addr;
    logic [15:0] r_wd;

    vecs[0] = '{5'b00001, 20'h00012, 16'h1234, 5'b00001, 20'h00012, 16'h1234, 1'b0};
    vecs[1] = '{5'b00000, 20'h00012, 16'h1234, 5'b00000, 20'h00012, 16'h1234, 1'b1};
    vecs[2] = '{5'b11111, 20'hFFFFF, 16'hFFFF, 5'b11111, 20'hFFFFF, 16'hFFFF, 1'b0};
    vecs[3] = '{5'b01010, 20'h80001, 16'h0001, 5'b01010, 20'h80001, 16'h0001, 1'b1};
    vecs[4] = '{5'b10101, 20'h00000, 16'h8000, 5'b10101, 20'h00000, 16'h8000, 1'b0};

    Reset  = 1'b0;
    Reload = 1'b0;
    cpu_idle();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ctl",      64'(sram_ctl), 64'(5'b11111));
    chk("rst_drive",    64'(sram_drive), 64'd0);
    chk("rst_addr",     64'(sram_if.ADDR), 64'd0);
    chk("rst_data",     64'(sram_if.data_write), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_count",    64'(load_count), 64'd0);
    chk("rst_hold",     64'(cpu_hold), 64'd1);
    chk("rst_done",     64'(init_done), 64'd0);
    chk("rst_n0_done",  64'(init_done0), 64'd0);
    chk("rst_n0_we",    64'(sram0_if.WE), 64'd1);

    // copy of 4 words with CPU traffic ignored
    wlog.delete();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("n0_done_first", 64'(init_done0), 64'd1);
    chk("n0_hold_first", 64'(cpu_hold0), 64'd0);
    wait_done(1'b1, 1'b0, 1, cyc);
    chk("t1_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check_writes("t1");
    chk("t1_count", 64'(load_count), 64'(N));
    chk("t1_hold",  64'(cpu_hold), 64'd0);

    // pass-through table
    for (int i = 0; i < 5; i++) begin
      {cpu_if.CE, cpu_if.UB, cpu_if.LB, cpu_if.OE, cpu_if.WE} = vecs[i].ctl;
      cpu_if.ADDR       = vecs[i].addr;
      cpu_if.data_write = vecs[i].wd;
      #1;
      chk("pt_ctl",   64'(sram_ctl), 64'(vecs[i].e_ctl));
      chk("pt_addr",  64'(sram_if.ADDR), 64'(vecs[i].e_addr));
      chk("pt_wd",    64'(sram_if.data_write), 64'(vecs[i].e_wd));
      chk("pt_drive", 64'(sram_drive), 64'(vecs[i].e_drive));
      chk("pt0_all",  64'({sram0_ctl, sram0_if.ADDR, sram0_if.data_write, sram_drive0}),
                      64'({vecs[i].e_ctl, vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_drive}));
      #1;
    end

    // random pass-through against the model: pins mirror CPU, drive follows write-enable
    for (int i = 0; i < 30; i++) begin
      r_ctl  = 5'($urandom);
      r_addr = 20'($urandom);
      r_wd   = 16'($urandom);
      {cpu_if.CE, cpu_if.UB, cpu_if.LB, cpu_if.OE, cpu_if.WE} = r_ctl;
      cpu_if.ADDR       = r_addr;
      cpu_if.data_write = r_wd;
      #1;
      chk("rnd_pt", 64'({sram_ctl, sram_if.ADDR, sram_if.data_write, sram_drive}),
                    64'({r_ctl, r_addr, r_wd, ~r_ctl[0]}));
      #2;
    end
    cpu_idle();

    // reload from DONE, with Reload pulses during the copy
    @(posedge Clk);
    #1;
    wlog.delete();
    cpu_if.WE = 1'b0;
    Reload    = 1'b1;
    @(posedge Clk);
    #1;
    Reload = 1'b0;
    chk("t4_hold",  64'(cpu_hold), 64'd1);
    chk("t4_done",  64'(init_done), 64'd0);
    chk("t4_count", 64'(load_count), 64'd0);
    chk("t4_we",    64'(sram_if.WE), 64'd1);
    chk("t4_drive", 64'(sram_drive), 64'd0);
    wait_done(1'b1, 1'b1, 0, cyc);
    chk("t4_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check_writes("t4");
    chk("t4_final_count", 64'(load_count), 64'(N));

    // reset during the write of word 2
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge Clk);
      if (cpu_hold && !sram_if.WE && sram_if.ADDR == 20'd2) found = 1'b1;
    end
    chk("t3_found_word2", 64'(found), 64'd1);
    chk("t3_count_mid",   64'(load_count), 64'd2);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("t3_we",       64'(sram_if.WE), 64'd1);
    chk("t3_drive",    64'(sram_drive), 64'd0);
    chk("t3_count",    64'(load_count), 64'd0);
    chk("t3_hold",     64'(cpu_hold), 64'd1);
    chk("t3_rom_addr", 64'(rom_addr), 64'd0);
    @(negedge Clk);
    #1;
    wlog.delete();
    Reset = 1'b1;
    wait_done(1'b0, 1'b0, 0, cyc);
    chk("t3_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check_writes("t3");
    chk("t3_final_count", 64'(load_count), 64'(N));
    chk("n0_done_end",    64'(init_done0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
